// File: rtl/corr_sample_feeder.sv
// corr_sample_feeder: gathers complex 8-bit samples into a vector buffer,
// writes the vector two samples per word into the accelerator sample window,
// starts the accelerator, waits for calc-finish, and repeats INT_LENGTH times.
module corr_sample_feeder #(
    parameter int FIFO_BASE_ADDR = 99,
    parameter int TWIDTH         = 3,
    parameter int CHNUM          = 2,
    parameter int INT_LENGTH     = 10,
    parameter int IDWIDTH        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               smpl_valid_i,
    output logic               smpl_ready_o,
    input  logic [IDWIDTH-1:0] smpl_re_i,
    input  logic [IDWIDTH-1:0] smpl_im_i,
    output logic               mem_req_o,
    input  logic               mem_ack_i,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic [3:0]         mem_be_o,
    output logic               acc_start_o,
    input  logic               acc_ready_i,
    input  logic               calc_fin_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [7:0]         vec_cnt_o
);

    localparam int MUL_NUM = CHNUM * TWIDTH;
    localparam int NWORDS  = MUL_NUM / 2;
    localparam int KW      = (MUL_NUM > 1) ? $clog2(MUL_NUM) : 1;
    localparam int WW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(MUL_NUM - 1);
    localparam logic [WW-1:0] W_LAST   = WW'(NWORDS - 1);
    localparam logic [7:0]    VEC_LAST = 8'(INT_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WRITE, S_START, S_WAIT_FIN, S_DONE
    } state_t;

    state_t              state_q;
    logic [KW-1:0]       k_q;
    logic [WW-1:0]       w_q;
    logic                smpl_ready_q;
    logic                req_q;
    logic                start_q;
    logic                busy_q;
    logic                done_q;
    logic [7:0]          vec_cnt_q;
    logic [7:0]          vec_cnt_d;
    logic [IDWIDTH-1:0]  re_q [MUL_NUM];
    logic [IDWIDTH-1:0]  im_q [MUL_NUM];
    logic [31:0]         word_d;
    logic                smpl_hs;

    assign smpl_hs   = smpl_valid_i & smpl_ready_q;
    assign vec_cnt_d = vec_cnt_q + 8'd1;

    // Sample buffer: data only, no reset needed since contents are rewritten each vector.
    always_ff @(posedge clk) begin
        if (smpl_hs) begin
            re_q[k_q] <= smpl_re_i;
            im_q[k_q] <= smpl_im_i;
        end
    end

    // Select the packed word w: {im[2w+1], re[2w+1], im[2w], re[2w]}.
    always_comb begin
        word_d = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (w_q == WW'(i)) begin
                word_d = {im_q[2*i+1], re_q[2*i+1], im_q[2*i], re_q[2*i]};
            end
        end
    end

    // Main sequencer; every output is a register or a decode of registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            w_q          <= '0;
            smpl_ready_q <= 1'b0;
            req_q        <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vec_cnt_q    <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q      <= S_FILL;
                        k_q          <= '0;
                        w_q          <= '0;
                        vec_cnt_q    <= '0;
                        smpl_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (smpl_hs) begin
                        if (k_q == K_LAST) begin
                            k_q          <= '0;
                            w_q          <= '0;
                            smpl_ready_q <= 1'b0;
                            req_q        <= 1'b1;
                            state_q      <= S_WRITE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // req stays high across words so back-to-back acks need no idle cycle
                    if (mem_ack_i) begin
                        if (w_q == W_LAST) begin
                            w_q     <= '0;
                            req_q   <= 1'b0;
                            start_q <= acc_ready_i;
                            state_q <= S_START;
                        end else begin
                            w_q <= w_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    // start pulse is registered: it follows the cycle ready was seen high
                    if (start_q) begin
                        state_q <= S_WAIT_FIN;
                    end else begin
                        start_q <= acc_ready_i;
                    end
                end
                S_WAIT_FIN: begin
                    if (calc_fin_i) begin
                        vec_cnt_q <= vec_cnt_d;
                        if (vec_cnt_d == VEC_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            smpl_ready_q <= 1'b1;
                            state_q      <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign smpl_ready_o = smpl_ready_q;
    assign mem_req_o    = req_q;
    assign mem_we_o     = req_q;
    assign mem_be_o     = {4{req_q}};
    assign mem_addr_o   = req_q ? (32'(FIFO_BASE_ADDR) + 32'(w_q)) : 32'd0;
    assign mem_wdata_o  = req_q ? word_d : 32'd0;
    assign acc_start_o  = start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign vec_cnt_o    = vec_cnt_q;

endmodule

// File: tb/tb_corr_sample_feeder.sv
// Bench for corr_sample_feeder: a bus slave, sample source and accelerator
// are emulated cycle by cycle; writes are checked against the packing rule.
module tb_corr_sample_feeder;

    localparam int BASE = 99;
    localparam int TW   = 3;
    localparam int CH   = 2;
    localparam int INTL = 10;
    localparam int MN   = CH * TW;
    localparam int NW   = MN / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_i, smpl_valid_i, smpl_ready_o;
    logic [7:0]  smpl_re_i, smpl_im_i;
    logic        mem_req_o, mem_ack_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        acc_start_o, acc_ready_i, calc_fin_i, busy_o, done_o;
    logic [7:0]  vec_cnt_o;

    always #5 clk = ~clk;

    corr_sample_feeder #(
        .FIFO_BASE_ADDR(BASE), .TWIDTH(TW), .CHNUM(CH), .INT_LENGTH(INTL), .IDWIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .run_i(run_i),
        .smpl_valid_i(smpl_valid_i), .smpl_ready_o(smpl_ready_o),
        .smpl_re_i(smpl_re_i), .smpl_im_i(smpl_im_i),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .acc_start_o(acc_start_o), .acc_ready_i(acc_ready_i), .calc_fin_i(calc_fin_i),
        .busy_o(busy_o), .done_o(done_o), .vec_cnt_o(vec_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] src_q[$];
    logic [15:0] gen_q[$];
    logic [63:0] wr_q[$];

    int ack_delay, ack_wait, rdy_block, fin_lat, fin_timer, model_vec;
    int n_start, n_done, n_bad_start, n_unstable, smpl_in_vec, wr_in_vec;
    bit noise, start_req, exp_run, exp_req, exp_start, exp_fin, prev_done;
    bit prev_req, prev_ack, prev_rdy;
    logic [31:0] prev_addr, prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bench cycle: observe outputs at negedge, then drive inputs for the next posedge.
    task automatic cycle();
        @(negedge clk);
        if (exp_run) begin
            check("ready_after_run", smpl_ready_o, 1);
            check("vec_cnt_at_run", vec_cnt_o, 0);
            check("busy_after_run", busy_o, 1);
            exp_run = 0;
        end
        if (exp_req) begin
            check("req_after_last_sample", mem_req_o, 1);
            exp_req = 0;
        end
        if (exp_start) begin
            check("start_after_ready", acc_start_o, 1);
            exp_start = 0;
        end
        if (exp_fin) begin
            check("vec_cnt_after_fin", vec_cnt_o, 64'(model_vec));
            check("next_after_fin", (model_vec == INTL) ? done_o : smpl_ready_o, 1);
            exp_fin = 0;
        end
        if (prev_done) begin
            check("busy_low_after_done", busy_o, 0);
            prev_done = 0;
        end
        if (done_o) begin
            n_done++;
            prev_done = 1;
        end
        if (prev_req && !prev_ack) begin
            if (!mem_req_o || mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) n_unstable++;
        end
        if (mem_req_o && (mem_we_o !== 1'b1 || mem_be_o !== 4'hF)) n_unstable++;
        if (acc_start_o) begin
            n_start++;
            if (!prev_rdy) n_bad_start++;
            fin_timer = fin_lat;
            wr_in_vec = 0;
        end

        // accelerator finish
        calc_fin_i = 1'b0;
        if (fin_timer > 0 && !acc_start_o) begin
            fin_timer--;
            if (fin_timer == 0) begin
                calc_fin_i = 1'b1;
                model_vec++;
                exp_fin = 1;
            end
        end else if (noise && smpl_ready_o && $urandom_range(0, 3) == 0) begin
            calc_fin_i = 1'b1;
        end

        // accelerator ready
        acc_ready_i = (rdy_block == 0);
        if (rdy_block > 0 && wr_in_vec == NW) rdy_block--;

        // bus slave
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
            if (ack_wait >= ack_delay) begin
                mem_ack_i = 1'b1;
                ack_wait  = 0;
                wr_q.push_back({mem_addr_o, mem_wdata_o});
                wr_in_vec++;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
            if (noise) mem_ack_i = 1'($urandom_range(0, 1));
        end
        if (wr_in_vec == NW && acc_ready_i) exp_start = 1;

        // sample source
        smpl_valid_i = 1'b0;
        if (src_q.size() > 0 && (!noise || $urandom_range(0, 3) != 0)) begin
            smpl_valid_i = 1'b1;
            {smpl_im_i, smpl_re_i} = src_q[0];
        end
        if (smpl_valid_i && smpl_ready_o) begin
            void'(src_q.pop_front());
            smpl_in_vec++;
            if (smpl_in_vec == MN) begin
                smpl_in_vec = 0;
                exp_req = 1;
            end
        end

        // run control
        run_i = 1'b0;
        if (start_req) begin
            run_i     = 1'b1;
            start_req = 0;
            exp_run   = 1;
        end else if (noise && busy_o && $urandom_range(0, 3) == 0) begin
            run_i = 1'b1;
        end

        prev_req  = mem_req_o;
        prev_ack  = mem_ack_i;
        prev_addr = mem_addr_o;
        prev_data = mem_wdata_o;
        prev_rdy  = acc_ready_i;
    endtask

    task automatic setup_run(input bit directed, input int adly, input int rblk, input int flat, input bit nz);
        logic [15:0] s;
        logic [7:0]  n8;
        gen_q.delete();
        src_q.delete();
        wr_q.delete();
        for (int i = 0; i < INTL * MN; i++) begin
            n8 = 8'(i);
            if (directed && i < MN) s = {8'h80 + n8, n8};
            else s = 16'($urandom);
            gen_q.push_back(s);
            src_q.push_back(s);
        end
        ack_delay = adly; rdy_block = rblk; fin_lat = flat; noise = nz;
        n_start = 0; n_done = 0; n_bad_start = 0; n_unstable = 0;
        model_vec = 0; smpl_in_vec = 0; wr_in_vec = 0; fin_timer = 0; ack_wait = 0;
        start_req = 1;
    endtask

    task automatic finish_run(input string tag);
        int cyc;
        int lim;
        logic [63:0] e;
        cyc = 0;
        while (n_done == 0 && cyc < 3000) begin
            cycle();
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(n_done), 1);
        cycle();
        check({tag, "_done_pulses"}, 64'(n_done), 1);
        check({tag, "_write_count"}, 64'(wr_q.size()), 64'(INTL * NW));
        check({tag, "_start_count"}, 64'(n_start), 64'(INTL));
        check({tag, "_start_without_ready"}, 64'(n_bad_start), 0);
        check({tag, "_bus_hold_violations"}, 64'(n_unstable), 0);
        check({tag, "_final_vec_cnt"}, vec_cnt_o, 64'(INTL));
        check({tag, "_idle_busy"}, busy_o, 0);
        lim = (wr_q.size() < INTL * NW) ? wr_q.size() : INTL * NW;
        for (int i = 0; i < lim; i++) begin
            int v;
            int w;
            v = i / NW;
            w = i % NW;
            e = {32'(BASE + w), gen_q[v * MN + 2 * w + 1], gen_q[v * MN + 2 * w]};
            check({tag, "_write"}, wr_q[i], e);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        run_i = 0; smpl_valid_i = 0; smpl_re_i = 0; smpl_im_i = 0;
        mem_ack_i = 0; acc_ready_i = 0; calc_fin_i = 0;
        noise = 0; start_req = 0; exp_run = 0; exp_req = 0; exp_start = 0; exp_fin = 0;
        prev_done = 0; prev_req = 0; prev_ack = 0; prev_rdy = 0; prev_addr = 0; prev_data = 0;
        fin_timer = 0; rdy_block = 0; wr_in_vec = 0; smpl_in_vec = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_be", mem_be_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_start", acc_start_o, 0);
        check("rst_ready", smpl_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_vec_cnt", vec_cnt_o, 0);
        rst = 1'b0;

        // directed first vector, zero-wait bus
        setup_run(1, 0, 0, 4, 0);
        finish_run("basic");
        if (wr_q.size() >= 3) begin
            check("basic_w0", wr_q[0], {32'd99, 32'h81018000});
            check("basic_w1", wr_q[1], {32'd100, 32'h83038202});
            check("basic_w2", wr_q[2], {32'd101, 32'h85058404});
        end

        // three wait cycles per word
        setup_run(0, 3, 0, 4, 0);
        finish_run("ackdly");

        // accelerator not ready for five cycles in START
        setup_run(0, 0, 5, 4, 0);
        finish_run("rdylow");

        // spurious calc_fin/run/ack and gapped source
        setup_run(0, 1, 0, 4, 1);
        finish_run("noise");

        // reset while word 1 of the second vector is pending
        setup_run(0, 2, 0, 4, 0);
        cyc = 0;
        while (!(wr_q.size() == NW + 1 && mem_req_o) && cyc < 2000) begin
            cycle();
            cyc++;
        end
        check("rst_mid_reached", 64'(cyc < 2000), 1);
        cycle();
        check("rst_mid_addr", mem_addr_o, 64'(BASE + 1));
        check("rst_mid_vec_cnt", vec_cnt_o, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", mem_req_o, 0);
        check("rst_mid_vec_clear", vec_cnt_o, 0);
        check("rst_mid_busy", busy_o, 0);
        run_i = 0; smpl_valid_i = 0; mem_ack_i = 0; acc_ready_i = 0; calc_fin_i = 0;
        src_q.delete();
        exp_run = 0; exp_req = 0; exp_start = 0; exp_fin = 0; prev_done = 0;
        prev_req = 0; prev_ack = 0; fin_timer = 0; wr_in_vec = 0; start_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        setup_run(0, 0, 0, 4, 0);
        finish_run("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
